// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: one 32-bit load/store becomes two 16-bit SRAM accesses.
// Optional last-word buffer enabled by defining SRAM_CTRL_LAST_WORD_EN.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic [31:0] eff;
    logic        req;
    logic        last_cnt;
    logic        hit;
    logic [31:0] hit_data;

    assign eff      = address - BASE_ADDR;
    assign req      = wr_en | rd_en;
    assign last_cnt = (cnt_q == LAST_CNT);

`ifdef SRAM_CTRL_LAST_WORD_EN
    logic        buf_valid_q;
    logic [29:0] buf_tag_q;
    logic [31:0] buf_data_q;
    logic        unused_bits;

    // Only a pure read can hit; a combined request is a write.
    assign hit      = (state_q == S_IDLE) & rd_en & ~wr_en & buf_valid_q & (buf_tag_q == eff[31:2]);
    assign hit_data = buf_data_q;
    assign unused_bits = ^eff[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else if (state_q == S_DONE) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= tag_q;
            buf_data_q  <= op_wr_q ? wdata_q : rdata_q;
        end
    end
`else
    logic unused_bits;

    assign hit         = 1'b0;
    assign hit_data    = '0;
    assign unused_bits = ^{eff[1:0], tag_q[29:16]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            tag_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            tag_q    <= tag_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        tag_d    = tag_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = ~req;
                cnt_d = '0;
                if (hit) begin
                    ready   = 1'b1;
                    rdata_d = hit_data;
                end else if (req) begin
                    op_wr_d  = wr_en;
                    tag_d    = eff[31:2];
                    wdata_d  = write_data;
                    addr_d   = {eff[17:2], 1'b0};
                    dq_out_d = write_data[15:0];
                    state_d  = S_LOW;
                end
            end
            S_LOW: begin
                if (last_cnt) begin
                    cnt_d    = '0;
                    addr_d   = {tag_q[15:0], 1'b1};
                    dq_out_d = wdata_q[31:16];
                    state_d  = S_HIGH;
                    if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // The held request that caused this access is still present; ignore it.
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sram_dq_oe  = op_wr_q & ((state_q == S_LOW) | (state_q == S_HIGH));
    assign sram_we_n   = ~sram_dq_oe;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign read_data   = hit ? hit_data : rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed cases plus random loads/stores
// checked against a word-level memory model and per-cycle SRAM bus expectations.
module tb_sram_controller;

    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_CTRL_LAST_WORD_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device model: 1024 halfwords, address aliased on low 10 bits.
    logic [15:0] sram_mem [0:1023];
    int          wr_events = 0;
    assign sram_dq_in = sram_mem[sram_addr[9:0]];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq_out;
            wr_events <= wr_events + 1;
        end
    end

    // Reference model: 32-bit word memory plus last-word buffer state.
    logic [31:0] ref_word [0:511];
    logic [31:0] last_rd;
    bit          buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the completing cycle.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wd, input bit release_req);
        logic [31:0] eff;
        logic [29:0] tag;
        int unsigned hw;
        int          w9, k, we_low, exp_lat;
        logic [17:0] a_lo, a_hi, addr_before;
        logic [31:0] exp_rd;
        bit          is_wr, hit, done;

        eff    = addr - BASE;
        tag    = eff[31:2];
        hw     = (eff >> 2) & 32'h0000FFFF;
        a_lo   = 18'(hw * 2);
        a_hi   = 18'(hw * 2 + 1);
        w9     = int'(hw % 512);
        is_wr  = wr;
        hit    = FEAT && !wr && rd && buf_valid && (buf_tag == tag);
        exp_lat = hit ? 0 : 2 * AC + 1;
        exp_rd = is_wr ? last_rd : (hit ? buf_data : ref_word[w9]);
        addr_before = sram_addr;

        wr_en = wr; rd_en = rd; address = addr; write_data = wd;
        k = 0; done = 0; we_low = 0;
        while (!done && k <= 4 * AC + 8) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                if (k == 0) begin
                    check("idle_we_n", sram_we_n, 1'b1);
                end else begin
                    check("sram_addr", sram_addr, (k <= AC) ? a_lo : a_hi);
                    if (is_wr) check("dq_out", sram_dq_out, (k <= AC) ? wd[15:0] : wd[31:16]);
                    check("dq_oe", sram_dq_oe, is_wr);
                    if (!sram_we_n) we_low++;
                    if (k == 1) begin
                        address    = $urandom;
                        write_data = $urandom;
                    end
                end
                k++;
            end
        end
        check("latency", k, exp_lat);
        check("we_low_cycles", we_low, is_wr ? 2 * AC : 0);
        check("read_data", read_data, exp_rd);
        if (hit) check("hit_addr_still", sram_addr, addr_before);

        if (is_wr) ref_word[w9] = wd;
        else       last_rd = exp_rd;
        if (FEAT && !hit) begin
            buf_valid = 1;
            buf_tag   = tag;
            buf_data  = is_wr ? wd : exp_rd;
        end

        @(posedge clk); #1;
        if (release_req) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_ready", ready, 1'b1);
        check("idle_we_n", sram_we_n, 1'b1);
        check("idle_oe", sram_dq_oe, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wcount;
        int sel;
        logic [31:0] a;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'($urandom);
        for (int i = 0; i < 512; i++) ref_word[i] = {sram_mem[2*i+1], sram_mem[2*i]};
        last_rd = '0; buf_valid = 0; buf_tag = '0; buf_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe", sram_dq_oe, 1'b0);
        check("rst_sram_addr", sram_addr, 18'd0);
        check("rst_dq_out", sram_dq_out, 16'd0);
        check("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then load of one word
        run_access(1, 0, 32'd1028, 32'hDEADBEEF, 1);
        idle_check();
        run_access(0, 1, 32'd1028, 32'h0, 1);
        check("dir_read_1028", read_data, 32'hDEADBEEF);

        // Load with known SRAM contents
        sram_mem[0] = 16'h1234; sram_mem[1] = 16'hABCD; ref_word[0] = 32'hABCD1234;
        run_access(0, 1, 32'd1024, 32'h0, 1);
        check("dir_read_1024", read_data, 32'hABCD1234);

        // Simultaneous request is a write
        run_access(1, 1, 32'd1032, 32'h11112222, 1);
        check("both_mem_lo", sram_mem[4], 16'h2222);
        check("both_mem_hi", sram_mem[5], 16'h1111);

        // Reset during the high half of a write
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
        for (int i = 0; i <= AC + 1; i++) @(negedge clk);
        check("pre_rst_we_n", sram_we_n, 1'b0);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("post_rst_we_n", sram_we_n, 1'b1);
        check("post_rst_oe", sram_dq_oe, 1'b0);
        check("post_rst_ready", ready, 1'b1);
        wcount = wr_events;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_write_after_rst", wr_events, wcount);
        ref_word[3] = {sram_mem[7], sram_mem[6]};
        last_rd = '0; buf_valid = 0;
        @(posedge clk); #1;

        // Back-to-back held reads
        run_access(0, 1, 32'd1024, 32'h0, 0);
        run_access(0, 1, 32'd1028, 32'h0, 1);
        idle_check();

        // Last-word buffer scenario (full accesses when the buffer is absent)
        run_access(1, 0, 32'd1040, 32'h55AA55AA, 1);
        run_access(0, 1, 32'd1040, 32'h0, 1);
        check("buf_read_1040", read_data, 32'h55AA55AA);
        run_access(0, 1, 32'd1044, 32'h0, 1);

        // Random traffic, including addresses below the base (wrap)
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0)
                a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            else
                a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            run_access(sel != 1, sel != 0, a, $urandom, (n == 59) || ($urandom_range(0, 1) == 1));
            if (!wr_en && !rd_en && $urandom_range(0, 3) == 0) idle_check();
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
